// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// RV32 load/store width codes, FSM state encoding and alignment helpers.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Byte offset forced to the natural alignment of the access size.
  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] off;
    case (f3[1:0])
      2'b00:   off = a;
      2'b01:   off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      default: mis = |a;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load-data alignment and sign/zero extension; shared with the
// forwarding path so both see identical load results.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] ext
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU:   ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/gnt/rvalid bus master with lane
// alignment, load extension and pipeline stall. MEM_MISALIGN_TRAP_EN enables the misalignment trap.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_memread,
  input  logic                  mem_memwrite,
  input  logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] mem_load_data,
  output logic                  mem_stall,
  output logic                  mem_misalign
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic [DATA_WIDTH-1:0] load_hold_q, load_hold_d;

  logic                  access;
  logic                  is_load;
  logic                  misalign;
  logic                  issue;
  logic [1:0]            offset_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [3:0]            be_in;
  logic [DATA_WIDTH-1:0] wdata_in;
  logic [DATA_WIDTH-1:0] ext_data;

  // Gating with rst keeps req/stall low while reset is held even if EX/MEM still shows an access.
  assign access    = (mem_memread | mem_memwrite) & ~rst;
  assign is_load   = mem_memread;
  assign offset_in = align_offset(mem_funct3, mem_alu_result[1:0]);
  assign addr_in   = {mem_alu_result[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access & (state_q == ST_IDLE) &
                    is_misaligned(mem_funct3, mem_alu_result[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign issue        = access & ~misalign;
  assign mem_misalign = misalign;

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = mem_writedata;
    case (mem_funct3[1:0])
      2'b00: begin
        be_in    = 4'b0001 << offset_in;
        wdata_in = {4{mem_writedata[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << offset_in;
        wdata_in = {2{mem_writedata[15:0]}};
      end
      default: ;
    endcase
  end

  mem_access_unit_load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .rdata  (dmem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .ext    (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    offset_d      = offset_q;
    load_hold_d   = load_hold_q;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_be       = '0;
    dmem_wdata    = '0;
    mem_stall     = 1'b0;
    mem_load_data = misalign ? '0 : load_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          dmem_req   = 1'b1;
          dmem_we    = ~is_load;
          dmem_addr  = addr_in;
          dmem_be    = be_in;
          dmem_wdata = wdata_in;
          mem_stall  = ~(~is_load & dmem_gnt);
          addr_d     = addr_in;
          be_d       = be_in;
          wdata_d    = wdata_in;
          we_d       = ~is_load;
          funct3_d   = mem_funct3;
          offset_d   = offset_in;
          if (is_load) state_d = dmem_gnt ? ST_WAIT : ST_REQ;
          else         state_d = dmem_gnt ? ST_IDLE : ST_REQ;
        end
      end
      ST_REQ: begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_be    = be_q;
        dmem_wdata = wdata_q;
        mem_stall  = ~(we_q & dmem_gnt);
        if (dmem_gnt) state_d = we_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        mem_stall = ~dmem_rvalid;
        if (dmem_rvalid) begin
          mem_load_data = ext_data;
          load_hold_d   = ext_data;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      load_hold_q <= load_hold_d;
    end
  end

  // Request attributes are only observed outside IDLE, after being loaded, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    be_q     <= be_d;
    wdata_q  <= wdata_d;
    we_q     <= we_d;
    funct3_q <= funct3_d;
    offset_q <= offset_d;
  end

endmodule
